// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - simple dual-port storage array, registered write, asynchronous read
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 4
) (
  input  logic                  clk,
  input  logic                  w_en,
  input  logic [ADDR_SIZE-1:0]  w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [ADDR_SIZE-1:0]  r_addr,
  output logic [DATA_WIDTH-1:0] r_data
);

  localparam int DEPTH = 1 << ADDR_SIZE;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (w_en) begin
      mem_q[w_addr] <= w_data;
    end
  end

  // Asynchronous read gives first-word-fall-through on the head entry.
  assign r_data = mem_q[r_addr];

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FWFT FIFO with thresholds and count; SYNC_FIFO_ERR_EN adds sticky overflow/underflow flags
module sync_fifo #(
  parameter int DATA_WIDTH       = 8,
  parameter int ADDR_SIZE        = 4,
  parameter int ALMOST_FULL_GAP  = 1,
  parameter int ALMOST_EMPTY_GAP = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  w_inc,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_full,
  output logic                  w_almost_full,
  output logic                  w_overflow,
  input  logic                  r_inc,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_empty,
  output logic                  r_almost_empty,
  output logic                  r_underflow,
  output logic [ADDR_SIZE:0]    r_count
);

  localparam int DEPTH     = 1 << ADDR_SIZE;
  localparam int PTR_WIDTH = ADDR_SIZE + 1;

  localparam logic [PTR_WIDTH-1:0] FULL_LEVEL = PTR_WIDTH'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] AF_LEVEL   = PTR_WIDTH'(DEPTH - ALMOST_FULL_GAP);
  localparam logic [PTR_WIDTH-1:0] AE_LEVEL   = PTR_WIDTH'(ALMOST_EMPTY_GAP);

  logic [PTR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [PTR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic                 w_accept, r_accept;

  // The extra MSB makes the modular difference range over 0..DEPTH.
  assign r_count        = w_ptr_q - r_ptr_q;
  assign w_full         = (r_count == FULL_LEVEL);
  assign r_empty        = (r_count == '0);
  assign w_almost_full  = (r_count >= AF_LEVEL);
  assign r_almost_empty = (r_count <= AE_LEVEL);

  assign w_accept = w_inc && !w_full;
  assign r_accept = r_inc && !r_empty;

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    if (w_accept) begin
      w_ptr_d = w_ptr_q + PTR_WIDTH'(1);
    end
    if (r_accept) begin
      r_ptr_d = r_ptr_q + PTR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_mem (
    .clk   (clk),
    .w_en  (w_accept && !reset),
    .w_addr(w_ptr_q[ADDR_SIZE-1:0]),
    .w_data(w_data),
    .r_addr(r_ptr_q[ADDR_SIZE-1:0]),
    .r_data(r_data)
  );

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (w_inc & w_full);
    underflow_d = underflow_q | (r_inc & r_empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign w_overflow  = overflow_q;
  assign r_underflow = underflow_q;
`else
  assign w_overflow  = 1'b0;
  assign r_underflow = 1'b0;
`endif

endmodule
